// File: rtl/hazard_control_unit.sv
// Hazard and stall controller for the 5-stage rv32i pipeline: load-use bubbles,
// memory-wait freezes, taken-branch flushes and hazard event counters.
module hazard_control_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_uses_src1,
  input  logic             id_uses_src2,
  input  logic [4:0]       ex_dest,
  input  logic             ex_ld_regfile,
  input  logic             ex_dmem_read,
  input  logic             ex_br_taken,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  state_e state_q, state_d;

  logic freeze;
  logic lu_hazard;
  logic bubble_commit;
  logic flush_commit;

  logic [CNT_W-1:0] freeze_cnt_q, bubble_cnt_q, flush_cnt_q;

  assign freeze = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);

  // x0 is never a real dependency, so a load to x0 cannot stall.
  assign lu_hazard = ex_dmem_read & ex_ld_regfile & (ex_dest != 5'd0) &
                     ((id_uses_src1 & (id_src1 == ex_dest)) |
                      (id_uses_src2 & (id_src2 == ex_dest)));

  assign flush_commit  = ex_br_taken & ~freeze;
  assign bubble_commit = lu_hazard & (state_q == StRun) & ~freeze & ~ex_br_taken;

  always_comb begin
    state_d      = state_q;
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (!rst || freeze) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (ex_br_taken) begin
      // Wrong-path load-use is discarded along with the flushed instructions.
      bubble_id_ex = 1'b1;
      flush_if_id  = 1'b1;
      state_d      = StRun;
    end else if (bubble_commit) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      bubble_id_ex = 1'b1;
      state_d      = StBubble;
    end else begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StRun;
      freeze_cnt_q <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (freeze)        freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
      if (bubble_commit) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      if (flush_commit)  flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign freeze_cnt = freeze_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit; a narrow-counter instance shares the
// inputs so counter wrap-around is reachable in a short run.
module tb_hazard_control_unit;

  logic       clk, rst;
  logic [4:0] id_src1, id_src2, ex_dest;
  logic       id_uses_src1, id_uses_src2, ex_ld_regfile, ex_dmem_read, ex_br_taken;
  logic       imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;

  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        bubble_id_ex, flush_if_id;
  logic [31:0] freeze_cnt, bubble_cnt, flush_cnt;

  logic        s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
  logic        s_bubble_id_ex, s_flush_if_id;
  logic [2:0]  s_freeze_cnt, s_bubble_cnt, s_flush_cnt;

  hazard_control_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
    .ex_dest(ex_dest), .ex_ld_regfile(ex_ld_regfile), .ex_dmem_read(ex_dmem_read),
    .ex_br_taken(ex_br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .freeze_cnt(freeze_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  hazard_control_unit #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
    .ex_dest(ex_dest), .ex_ld_regfile(ex_ld_regfile), .ex_dmem_read(ex_dmem_read),
    .ex_br_taken(ex_br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .load_pc(s_load_pc), .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex),
    .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
    .bubble_id_ex(s_bubble_id_ex), .flush_if_id(s_flush_if_id),
    .freeze_cnt(s_freeze_cnt), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [6:0]  ctrl;
    logic [31:0] frz;
    logic [31:0] bub;
    logic [31:0] fl;
  } exp_t;

  exp_t sb[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state.
  logic        m_bubble;
  logic [31:0] m_frz, m_bub, m_fl;

  function automatic logic [6:0] ctrl_obs();
    return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id};
  endfunction

  function automatic logic [6:0] small_ctrl_obs();
    return {s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb,
            s_bubble_id_ex, s_flush_if_id};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_src1 = 5'd0; id_src2 = 5'd0; id_uses_src1 = 1'b0; id_uses_src2 = 1'b0;
    ex_dest = 5'd0; ex_ld_regfile = 1'b0; ex_dmem_read = 1'b0; ex_br_taken = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0;
    dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] dest, input logic [4:0] s1, input logic [4:0] s2,
                          input logic u1, input logic u2);
    ex_dmem_read = 1'b1; ex_ld_regfile = 1'b1; ex_dest = dest;
    id_src1 = s1; id_src2 = s2; id_uses_src1 = u1; id_uses_src2 = u2;
  endtask

  // Model one cycle from the current inputs, push the expectation, then compare
  // control outputs mid-cycle and counters just after the rising edge.
  task automatic cyc(input string tag);
    exp_t e;
    exp_t got;
    logic frz, lu;
    rst = 1'b1;
    frz = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
    lu  = ex_dmem_read & ex_ld_regfile & (ex_dest != 5'd0) &
          ((id_uses_src1 & (id_src1 == ex_dest)) | (id_uses_src2 & (id_src2 == ex_dest)));
    e.tag = tag;
    if (frz) begin
      e.ctrl = 7'b0000000;
      m_frz  = m_frz + 32'd1;
    end else if (ex_br_taken) begin
      e.ctrl   = 7'b1111111;
      m_fl     = m_fl + 32'd1;
      m_bubble = 1'b0;
    end else if (lu && !m_bubble) begin
      e.ctrl   = 7'b0011110;
      m_bub    = m_bub + 32'd1;
      m_bubble = 1'b1;
    end else begin
      e.ctrl   = 7'b1111100;
      m_bubble = 1'b0;
    end
    e.frz = m_frz; e.bub = m_bub; e.fl = m_fl;
    sb.push_back(e);

    @(negedge clk);
    #1;
    got = sb.pop_front();
    check_eq({got.tag, ".ctrl"}, {25'd0, ctrl_obs()}, {25'd0, got.ctrl});
    check_eq({got.tag, ".ctrl_s"}, {25'd0, small_ctrl_obs()}, {25'd0, got.ctrl});
    @(posedge clk);
    #1;
    check_eq({got.tag, ".freeze_cnt"}, freeze_cnt, got.frz);
    check_eq({got.tag, ".bubble_cnt"}, bubble_cnt, got.bub);
    check_eq({got.tag, ".flush_cnt"}, flush_cnt, got.fl);
    check_eq({got.tag, ".freeze_cnt_s"}, {29'd0, s_freeze_cnt}, {29'd0, got.frz[2:0]});
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".ctrl"}, {25'd0, ctrl_obs()}, 32'd0);
    check_eq({tag, ".freeze_cnt"}, freeze_cnt, 32'd0);
    check_eq({tag, ".bubble_cnt"}, bubble_cnt, 32'd0);
    check_eq({tag, ".flush_cnt"}, flush_cnt, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    m_bubble = 1'b0; m_frz = '0; m_bub = '0; m_fl = '0;
    #3;
    check_reset_state("reset");

    cyc("idle");

    // lw x5; add x6,x5,x1 -> one bubble, then the hazard stays masked in BUBBLE.
    set_load(5'd5, 5'd5, 5'd1, 1'b1, 1'b1);
    cyc("lu_src1");
    cyc("lu_masked");
    idle();
    cyc("after_bubble");

    set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cyc("load_x0");
    set_load(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
    cyc("lu_src2");
    set_load(5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    cyc("src2_unused");
    set_load(5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
    ex_ld_regfile = 1'b0;
    cyc("no_ld_regfile");

    // Data-memory wait for 4 cycles while a hazard is pending.
    set_load(5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
    dmem_read = 1'b1;
    for (int i = 0; i < 4; i++) cyc("dmem_freeze");
    dmem_resp = 1'b1;
    cyc("freeze_release_lu");
    idle();
    cyc("post_release");

    set_load(5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
    ex_br_taken = 1'b1;
    cyc("branch_with_lu");
    idle();
    cyc("after_branch");

    // Instruction-memory wait and store wait push the narrow counter past wrap.
    imem_read = 1'b1;
    for (int i = 0; i < 3; i++) cyc("imem_freeze");
    imem_read = 1'b0;
    dmem_write = 1'b1;
    for (int i = 0; i < 2; i++) cyc("store_freeze");
    dmem_resp = 1'b1;
    cyc("store_done");
    idle();
    check_eq("small_freeze_wrapped", {29'd0, s_freeze_cnt}, 32'd1);

    // BUBBLE is held across a freeze; branch under freeze is not committed.
    set_load(5'd12, 5'd12, 5'd0, 1'b1, 1'b0);
    cyc("lu_enter_bubble");
    imem_read = 1'b1;
    ex_br_taken = 1'b1;
    cyc("freeze_in_bubble");
    imem_read = 1'b0;
    ex_br_taken = 1'b0;
    cyc("bubble_release");
    cyc("lu_again");

    // Asynchronous reset mid-cycle while in BUBBLE with nonzero counters.
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("async_reset");
    m_bubble = 1'b0; m_frz = '0; m_bub = '0; m_fl = '0;
    cyc("lu_after_reset");
    idle();
    cyc("final_idle");

    check_eq("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and stall controller for the 5-stage rv32i core. Sits alongside the decode stage, directly upstream of the EX-stage forwarding logic: it detects load-use hazards that forwarding cannot resolve, inserts exactly one bubble into ID/EX, freezes the whole pipeline on outstanding instruction- or data-memory requests, and flushes wrong-path instructions on taken branches. It drives the load enables of the PC and all four pipeline registers, and keeps 32-bit hazard event counters for performance analysis.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- id_src1, id_src2  in  5 each (rv32i_reg)  source registers of the instruction in ID
- id_uses_src1, id_uses_src2  in  1 each  ID instruction actually reads src1/src2
- ex_dest  in  5  destination register of the instruction in EX
- ex_ld_regfile  in  1  EX instruction writes the regfile
- ex_dmem_read  in  1  EX instruction is a load
- ex_br_taken  in  1  EX-stage branch/jump resolved taken
- imem_read, imem_resp  in  1 each  instruction-memory request / response
- dmem_read, dmem_write, dmem_resp  in  1 each  MEM-stage data request / response
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
- bubble_id_ex  out  1  ID/EX loads a NOP (all control zero, ld_regfile=0)
- flush_if_id  out  1  IF/ID loads a NOP
- freeze_cnt, bubble_cnt, flush_cnt  out  CNT_W each  event counters

## Operation
- Derived terms:
  - freeze = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp)
  - lu_hazard = ex_dmem_read & ex_ld_regfile & (ex_dest != 0) & ((id_uses_src1 & id_src1 == ex_dest) | (id_uses_src2 & id_src2 == ex_dest))
- States: RUN, BUBBLE. In BUBBLE, lu_hazard is masked.
- Priority per cycle: reset > freeze > ex_br_taken > lu_hazard (RUN only) > normal.
- freeze: all five load_* = 0; bubble_id_ex = 0; flush_if_id = 0; state held.
- ex_br_taken (not frozen): all load_* = 1; flush_if_id = 1; bubble_id_ex = 1; next state RUN. A concurrent load-use is on the wrong path and is ignored.
- lu_hazard in RUN (not frozen, no branch): load_pc = 0, load_if_id = 0, load_id_ex = 1 with bubble_id_ex = 1, load_ex_mem = load_mem_wb = 1; next state BUBBLE.
- BUBBLE (not frozen): all load_* = 1, no bubble/flush; next state RUN. BUBBLE persists across freeze cycles.
- Normal: all load_* = 1, bubble_id_ex = flush_if_id = 0.
- Counters, all wrapping mod 2^CNT_W:
  - freeze_cnt += 1 per freeze cycle.
  - bubble_cnt += 1 per cycle the load-use bubble is committed (lu_hazard & RUN & ~freeze & ~ex_br_taken).
  - flush_cnt += 1 per committed flush (ex_br_taken & ~freeze).

## Timing
- All control outputs are combinational from inputs and state; state and counters are registered on clk rising edge.
- Reset (rst=0, asynchronous): state = RUN; all counters = 0; all load_*, bubble_id_ex, and flush_if_id forced to 0 while rst=0. Normal operation starts on the first edge after rst deasserts.
- Load-use penalty is exactly 1 cycle. The loaded value then reaches EX via MEM/WB forwarding.
- Freeze adds exactly one cycle per cycle freeze is high. A hazard present at freeze release is evaluated in the release cycle.
- Hazard arriving together with freeze: no bubble is taken and bubble_cnt does not change until freeze drops.
- Reset asserted mid-freeze or mid-BUBBLE: state returns to RUN immediately and counters clear.

## Test plan
- Load then dependent add (lw x5; add x6,x5,x1): ex_dest=5, ex_dmem_read=1, id_src1=5 -> one cycle with load_pc=0, load_if_id=0, bubble_id_ex=1, then all loads=1; bubble_cnt=1.
- Load to x0 with ID reading x0 -> no bubble; all loads=1; bubble_cnt=0.
- dmem_read=1, dmem_resp=0 for 4 cycles while lu_hazard=1 -> all load_*=0 for 4 cycles, freeze_cnt=4; bubble is taken in the 5th cycle, bubble_cnt=1.
- ex_br_taken=1 together with lu_hazard=1 -> flush_if_id=1, bubble_id_ex=1, load_pc=1; flush_cnt=1, bubble_cnt=0; state stays RUN.
- Preload freeze_cnt to 0xFFFFFFFF via sustained freeze (or forced value in the bench), then one more freeze cycle -> freeze_cnt wraps to 0.
- rst pulled low during BUBBLE with counters nonzero -> outputs go to 0 asynchronously, counters = 0, state RUN after release.
